pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Next-PC generation stage directly upstream of the PC register; its pc_next output drives PCin each cycle.
- Selects one of: sequential increment, PC-relative branch, absolute jump, call, or return.
- Holds a hardware return-address stack (RAS) for call/return, with full/empty status and sticky error flags.
- pc_next is combinational from the current PC and the stack top; all stack state is registered.

Parameters:
- WIDTH, 8, address width of the PC and all address ports.
- DEPTH, 4, number of RAS entries; power of two, 2..16.
- AW, $clog2(DEPTH), stack pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pc_cur  in  WIDTH  current PC; the PC register's PCout.
- stall  in  1  hold: pc_next = pc_cur, no stack update.
- branch_en  in  1  conditional branch instruction present.
- branch_taken  in  1  branch condition true.
- branch_off  in  WIDTH  signed two's-complement branch offset.
- jump_en  in  1  absolute jump.
- call_en  in  1  call: push return address, go to target_addr.
- ret_en  in  1  return: pop RAS, go to popped address.
- target_addr  in  WIDTH  jump/call destination.
- err_clr  in  1  clears the sticky error flags.
- pc_next  out  WIDTH  next PC; drives PCin.
- stack_empty  out  1  RAS holds 0 entries.
- stack_full  out  1  RAS holds DEPTH entries.
- stack_cnt  out  AW+1  current number of RAS entries.
- ovf_err  out  1  sticky: call attempted while full.
- unf_err  out  1  sticky: return attempted while empty.

Behaviour:
- Reset (async, rst=1): stack_cnt=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0, stack entries=0.
- While rst=1, pc_next is forced to 0, consistent with the PC register's reset value.
- Priority, when not stalled: ret_en > call_en > jump_en > (branch_en & branch_taken) > increment. Lower-priority requests in the same cycle are ignored, with no side effects.
- All arithmetic is modulo 2^WIDTH:
  - inc = pc_cur+1; 0xFF -> 0x00 for WIDTH=8.
  - branch: pc_next = pc_cur + 1 + branch_off, e.g. 0x10 + 1 + 0xFE = 0x0F.
  - branch_en with branch_taken=0 gives inc.
- jump: pc_next = target_addr; no stack change.
- call, not full:
  - pc_next = target_addr.
  - On the clock edge, push inc to stack[cnt] and increment cnt.
- call, full:
  - pc_next = target_addr; the push is discarded and cnt is unchanged.
  - ovf_err sets on the edge.
- ret, not empty:
  - pc_next = top entry (stack[cnt-1]), visible combinationally in the same cycle.
  - cnt decrements on the edge.
- ret, empty: pc_next = inc, cnt stays 0, unf_err sets on the edge.
- stall=1: pc_next = pc_cur. No push, pop, or error update. err_clr is still honoured.
- Sticky errors: set on an error event, cleared by err_clr. If err_clr coincides with a new error event, the error wins (flag stays 1).
- Status outputs are registered-derived:
  - stack_empty = (cnt==0).
  - stack_full = (cnt==DEPTH).
- Single-cycle latency: one instruction decision per clock, no internal pipeline.
- rst asserted mid-sequence immediately empties the stack. Contents become inaccessible, and a following ret produces unf_err.

Optional Feature:
- Macro: PC_RAS_WRAP_EN.
- Defined:
  - The RAS is circular. A call while full overwrites the oldest entry; cnt saturates at DEPTH and ovf_err is tied to 0.
  - A ret pops the newest entry as normal.
  - Example (DEPTH=4): after 5 calls, 4 returns yield the return addresses of calls 5, 4, 3, 2.
- Not defined: overflow behaviour as specified in Behaviour (push discarded, ovf_err set).

Test Plan:
- Reset/increment: rst pulse, then pc_cur=0x00, 0x01, 0xFF with no control inputs -> pc_next=0x01, 0x02, 0x00; stack_empty=1, stack_cnt=0.
- Branch: pc_cur=0x10, branch_en=1, branch_taken=1, branch_off=0xFE -> pc_next=0x0F. Same with branch_taken=0 -> 0x11. branch_off=0x05 -> 0x16.
- Nested call/return: call at pc_cur=0x20 to 0x40, then call at 0x45 to 0x80 -> stack_cnt=2. ret at 0x85 -> pc_next=0x46. ret -> pc_next=0x21, stack_empty=1.
- Overflow/underflow (DEPTH=4):
  - 5 calls -> 5th gives pc_next=target_addr, stack_cnt=4, ovf_err=1 (0 with PC_RAS_WRAP_EN).
  - ret on empty at pc_cur=0x30 -> pc_next=0x31, unf_err=1.
  - err_clr -> both 0.
- Priority/stall:
  - ret_en+call_en+jump_en together with stack top 0x55 -> pc_next=0x55, cnt decrements by 1, no push.
  - stall=1 with call_en=1 at pc_cur=0x12 -> pc_next=0x12, stack_cnt unchanged.
- Async reset mid-operation: with stack_cnt=3, assert rst between clock edges -> stack_cnt=0, stack_empty=1, pc_next=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC selection (increment / branch / jump / call / return)
// with a hardware return-address stack and sticky overflow/underflow flags.
// Optional build macro PC_RAS_WRAP_EN: circular RAS; a call while full
// overwrites the oldest entry and ovf_err never sets.
module pc_next_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pc_cur,
    input  logic             i_stall,
    input  logic             i_branch_en,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_off,
    input  logic             i_jump_en,
    input  logic             i_call_en,
    input  logic             i_ret_en,
    input  logic [WIDTH-1:0] i_target_addr,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_pc_next,
    output logic             o_stack_empty,
    output logic             o_stack_full,
    output logic [AW:0]      o_stack_cnt,
    output logic             o_ovf_err,
    output logic             o_unf_err
);

`ifdef PC_RAS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    // Stack storage; r_wp is the next write slot, so the top is r_wp-1.
    // In the non-wrapping build r_wp always equals cnt modulo DEPTH.
    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW:0]      r_cnt;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_top;
    logic [AW-1:0]    w_top_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_act;
    logic             w_do_call;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    assign w_inc     = i_pc_cur + 1'b1;
    assign w_top_idx = r_wp - 1'b1;
    assign w_top     = r_stack[w_top_idx];
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CNT_FULL);

    // A return outranks a call, so a call only acts when no return is present.
    assign w_act     = ~i_stall;
    assign w_do_call = w_act & ~i_ret_en & i_call_en;
    assign w_push    = w_do_call & (~w_full | WRAP);
    assign w_pop     = w_act & i_ret_en & ~w_empty;
    assign w_ovf_evt = w_do_call & w_full & ~WRAP;
    assign w_unf_evt = w_act & i_ret_en & w_empty;

    // Next-PC selection in priority order; reset forces the PC register's reset value.
    always_comb begin
        o_pc_next = w_inc;
        if (i_rst) begin
            o_pc_next = '0;
        end else if (i_stall) begin
            o_pc_next = i_pc_cur;
        end else if (i_ret_en) begin
            o_pc_next = w_empty ? w_inc : w_top;
        end else if (i_call_en || i_jump_en) begin
            o_pc_next = i_target_addr;
        end else if (i_branch_en && i_branch_taken) begin
            o_pc_next = w_inc + i_branch_off;
        end
    end

    // Return-address stack push/pop; a full push either wraps or is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[r_wp] <= w_inc;
            r_wp          <= r_wp + 1'b1;
            if (!w_full) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_pop) begin
            r_wp  <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign o_stack_empty = w_empty;
    assign o_stack_full  = w_full;
    assign o_stack_cnt   = r_cnt;
    assign o_ovf_err     = r_ovf;
    assign o_unf_err     = r_unf;

endmodule

// File: tb/tb_pc_next_unit.sv
// Testbench for pc_next_unit (WIDTH=8, DEPTH=4): table of combinational
// next-PC vectors plus directed multi-cycle stack sequences.
module tb_pc_next_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc_cur = '0;
    logic       stall = 1'b0;
    logic       br_en = 1'b0;
    logic       br_tk = 1'b0;
    logic [7:0] br_off = '0;
    logic       jmp = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] tgt = '0;
    logic       err_clr = 1'b0;
    logic [7:0] pc_next;
    logic       empty;
    logic       full;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;

    int n_tests = 0;
    int n_fail  = 0;

    pc_next_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pc_cur(pc_cur), .i_stall(stall),
        .i_branch_en(br_en), .i_branch_taken(br_tk), .i_branch_off(br_off),
        .i_jump_en(jmp), .i_call_en(call), .i_ret_en(ret),
        .i_target_addr(tgt), .i_err_clr(err_clr),
        .o_pc_next(pc_next), .o_stack_empty(empty), .o_stack_full(full),
        .o_stack_cnt(cnt), .o_ovf_err(ovf), .o_unf_err(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       stall;
        logic       br_en;
        logic       br_tk;
        logic [7:0] off;
        logic       jmp;
        logic       call;
        logic       ret;
        logic [7:0] tgt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; br_en = 1'b0; br_tk = 1'b0; br_off = '0;
        jmp = 1'b0; call = 1'b0; ret = 1'b0; tgt = '0; err_clr = 1'b0;
    endtask

    // Drive at the falling edge, then look at the combinational next PC.
    task automatic do_call(input logic [7:0] pc, input logic [7:0] t, input logic [7:0] exp_pc, input string name);
        @(negedge clk);
        idle(); pc_cur = pc; call = 1'b1; tgt = t;
        #1 check(name, pc_next, exp_pc);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_ret(input logic [7:0] pc, input logic [7:0] exp_pc, input string name);
        @(negedge clk);
        idle(); pc_cur = pc; ret = 1'b1;
        #1 check(name, pc_next, exp_pc);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             pc     stl   ben   btk   off    jmp   call  ret   tgt    exp
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
        vecs[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02};
        vecs[2]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{8'h10, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0F};
        vecs[4]  = '{8'h10, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
        vecs[5]  = '{8'h10, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h16};
        vecs[6]  = '{8'h7F, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h77, 8'h77};
        vecs[8]  = '{8'h10, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h77, 8'h77};
        vecs[9]  = '{8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40};
        vecs[10] = '{8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 8'h31};
        vecs[11] = '{8'h12, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h40, 8'h12};

        // Reset state
        #12;
        check("rst_pc_next", pc_next, 8'h00);
        check("rst_cnt", cnt, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_unf", unf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational vectors: applied and removed between rising edges
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pc_cur = vecs[i].pc; stall = vecs[i].stall; br_en = vecs[i].br_en;
            br_tk = vecs[i].br_tk; br_off = vecs[i].off; jmp = vecs[i].jmp;
            call = vecs[i].call; ret = vecs[i].ret; tgt = vecs[i].tgt;
            #1 check($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].exp);
            #1 idle();
        end
        check("vec_cnt", cnt, 3'd0);
        check("vec_empty", empty, 1'b1);

        // Nested call/return
        do_call(8'h20, 8'h40, 8'h40, "call1_pc");
        check("call1_cnt", cnt, 3'd1);
        do_call(8'h45, 8'h80, 8'h80, "call2_pc");
        check("call2_cnt", cnt, 3'd2);
        do_ret(8'h85, 8'h46, "ret1_pc");
        check("ret1_cnt", cnt, 3'd1);
        do_ret(8'h46, 8'h21, "ret2_pc");
        check("ret2_cnt", cnt, 3'd0);
        check("ret2_empty", empty, 1'b1);

        // Overflow: five calls into a four-entry stack
        for (int i = 1; i <= 4; i++) begin
            do_call(8'(i), 8'(8'hA0 + i), 8'(8'hA0 + i), $sformatf("ovf_call%0d_pc", i));
        end
        check("ovf_full_before", full, 1'b1);
        check("ovf_err_before", ovf, 1'b0);
        do_call(8'h05, 8'hA5, 8'hA5, "ovf_call5_pc");
        check("ovf_cnt", cnt, 3'd4);
        check("ovf_full", full, 1'b1);
`ifdef PC_RAS_WRAP_EN
        check("ovf_err", ovf, 1'b0);
        do_ret(8'hC0, 8'h06, "pop1_pc");
        do_ret(8'hC0, 8'h05, "pop2_pc");
        do_ret(8'hC0, 8'h04, "pop3_pc");
        do_ret(8'hC0, 8'h03, "pop4_pc");
`else
        check("ovf_err", ovf, 1'b1);
        do_ret(8'hC0, 8'h05, "pop1_pc");
        do_ret(8'hC0, 8'h04, "pop2_pc");
        do_ret(8'hC0, 8'h03, "pop3_pc");
        do_ret(8'hC0, 8'h02, "pop4_pc");
        check("ovf_sticky", ovf, 1'b1);
`endif
        check("pop_cnt", cnt, 3'd0);
        check("pop_unf", unf, 1'b0);

        // Underflow
        do_ret(8'h30, 8'h31, "unf_pc");
        check("unf_err", unf, 1'b1);
        check("unf_cnt", cnt, 3'd0);

        // Clear coinciding with a new underflow: the error wins
        @(negedge clk);
        pc_cur = 8'h30; ret = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        check("clr_vs_err_unf", unf, 1'b1);
        check("clr_vs_err_ovf", ovf, 1'b0);

        // Clear both flags
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        check("clr_ovf", ovf, 1'b0);
        check("clr_unf", unf, 1'b0);

        // Priority: ret beats call and jump
        do_call(8'h54, 8'h90, 8'h90, "prio_setup_pc");
        @(negedge clk);
        pc_cur = 8'h90; ret = 1'b1; call = 1'b1; jmp = 1'b1; tgt = 8'h99;
        #1 check("prio_pc", pc_next, 8'h55);
        @(posedge clk); #1;
        idle();
        check("prio_cnt", cnt, 3'd0);
        check("prio_ovf", ovf, 1'b0);

        // Stall: no push, no error update, clear still honoured
        @(negedge clk);
        pc_cur = 8'h12; stall = 1'b1; call = 1'b1; tgt = 8'h40;
        #1 check("stall_pc", pc_next, 8'h12);
        @(posedge clk); #1;
        idle();
        check("stall_cnt", cnt, 3'd0);
        @(negedge clk);
        pc_cur = 8'h12; stall = 1'b1; ret = 1'b1;
        @(posedge clk); #1;
        idle();
        check("stall_no_unf", unf, 1'b0);
        do_ret(8'h50, 8'h51, "stall_setup_unf");
        @(negedge clk);
        stall = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        check("stall_clr_unf", unf, 1'b0);

        // Asynchronous reset between edges with three entries stacked
        do_call(8'h10, 8'h20, 8'h20, "ar_call1");
        do_call(8'h11, 8'h20, 8'h20, "ar_call2");
        do_call(8'h12, 8'h20, 8'h20, "ar_call3");
        check("ar_cnt_before", cnt, 3'd3);
        @(negedge clk);
        pc_cur = 8'h33;
        #2 rst = 1'b1;
        #1 check("ar_cnt", cnt, 3'd0);
        check("ar_empty", empty, 1'b1);
        check("ar_pc_next", pc_next, 8'h00);
        rst = 1'b0;
        do_ret(8'h40, 8'h41, "ar_ret_pc");
        check("ar_ret_unf", unf, 1'b1);
        check("ar_ret_cnt", cnt, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
